// File: rtl/fifo_pkg.sv
// Shared FIFO pointer types and Gray-code helpers for the write/read pointer
// crossing logic.
package fifo_pkg;

    // Default FIFO address width; pointers carry one extra wrap bit.
    localparam int DEFAULT_ADDRSIZE = 7;
    localparam int DEPTH            = 2 ** DEFAULT_ADDRSIZE;

    // Pointer type for the default configuration.
    typedef logic [DEFAULT_ADDRSIZE:0] ptr_t;

    // Widest pointer the width-independent helpers handle. Narrower pointers
    // are zero-extended in; the leading zeros do not disturb the decode.
    localparam int GRAY_W_MAX = 16;
    typedef logic [GRAY_W_MAX-1:0] gray_wide_t;

    // Binary to Gray for the default pointer width.
    function automatic ptr_t bin2gray(input ptr_t bin);
        return bin ^ (bin >> 1);
    endfunction

    // Gray to binary for the default pointer width.
    function automatic ptr_t gray2bin(input ptr_t gray);
        ptr_t bin;
        bin[DEFAULT_ADDRSIZE] = gray[DEFAULT_ADDRSIZE];
        for (int i = DEFAULT_ADDRSIZE - 1; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

    // Gray to binary on the widest supported pointer, for parameterised users.
    function automatic gray_wide_t gray2bin_wide(input gray_wide_t gray);
        gray_wide_t bin;
        bin[GRAY_W_MAX-1] = gray[GRAY_W_MAX-1];
        for (int i = GRAY_W_MAX - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

    // True when more than one bit of the vector is set (clearing the lowest
    // set bit leaves something behind).
    function automatic logic multi_bit_wide(input gray_wide_t vec);
        return (vec & (vec - gray_wide_t'(1))) != {GRAY_W_MAX{1'b0}};
    endfunction

endpackage : fifo_pkg

// File: rtl/sync_ff_chain.sv
// Multi-flop synchroniser for a Gray-coded bus crossing into clk. Used for both
// pointer directions; the last stage is the registered output.
module sync_ff_chain #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] sync_r [STAGES];

    // Shift the asynchronous input through the flop chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                sync_r[i] <= {WIDTH{1'b0}};
            end
        end else begin
            sync_r[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                sync_r[i] <= sync_r[i-1];
            end
        end
    end

    assign q = sync_r[STAGES-1];

endmodule : sync_ff_chain

// File: rtl/r2w_ptr_sync.sv
// Write-domain receiver for the Gray read pointer: synchronises it, derives
// registered fill level / free space / almost-full, and raises sticky flags
// for illegal Gray steps and impossible levels.
module r2w_ptr_sync
    import fifo_pkg::*;
#(
    parameter int ADDRSIZE     = 7,
    parameter int SYNC_STAGES  = 2,
    parameter int AFULL_THRESH = 120
) (
    input  logic              wclk,
    input  logic              wrst_n,
    input  logic [ADDRSIZE:0] rptr_gray,
    input  logic [ADDRSIZE:0] wptr_gray,
    input  logic              err_clr,
    output logic [ADDRSIZE:0] r2wptr,
    output logic [ADDRSIZE:0] wlevel,
    output logic [ADDRSIZE:0] wspace,
    output logic              walmost_full,
    output logic              gray_err,
    output logic              level_err
);

    localparam int                PW        = ADDRSIZE + 1;
    localparam logic [ADDRSIZE:0] DEPTH_V   = {1'b1, {ADDRSIZE{1'b0}}};
    localparam logic [ADDRSIZE:0] THRESH_V  = PW'(AFULL_THRESH);

    logic [ADDRSIZE:0] r2wptr_d_r;
    logic [ADDRSIZE:0] rbin_s;
    logic [ADDRSIZE:0] wbin_s;
    logic [ADDRSIZE:0] diff_s;
    logic              over_s;
    logic              gray_step_bad_s;

    sync_ff_chain #(
        .WIDTH  (PW),
        .STAGES (SYNC_STAGES)
    ) u_rptr_sync (
        .clk   (wclk),
        .rst_n (wrst_n),
        .d     (rptr_gray),
        .q     (r2wptr)
    );

    // Decode both pointers and form the modular occupancy and violation terms.
    always_comb begin
        rbin_s          = PW'(gray2bin_wide(gray_wide_t'(r2wptr)));
        wbin_s          = PW'(gray2bin_wide(gray_wide_t'(wptr_gray)));
        diff_s          = wbin_s - rbin_s;
        over_s          = (diff_s > DEPTH_V);
        gray_step_bad_s = multi_bit_wide(gray_wide_t'(r2wptr ^ r2wptr_d_r));
    end

    // Remember the previous synchronised pointer for the Gray step check.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            r2wptr_d_r <= {PW{1'b0}};
        end else begin
            r2wptr_d_r <= r2wptr;
        end
    end

    // Register level, free space and almost-full; saturate an impossible level.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wlevel       <= {PW{1'b0}};
            wspace       <= DEPTH_V;
            walmost_full <= 1'b0;
        end else if (over_s) begin
            wlevel       <= DEPTH_V;
            wspace       <= {PW{1'b0}};
            walmost_full <= 1'b1;
        end else begin
            wlevel       <= diff_s;
            wspace       <= DEPTH_V - diff_s;
            walmost_full <= (diff_s >= THRESH_V);
        end
    end

    // Sticky Gray-step flag: a new violation beats a simultaneous clear.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            gray_err <= 1'b0;
        end else if (gray_step_bad_s) begin
            gray_err <= 1'b1;
        end else if (err_clr) begin
            gray_err <= 1'b0;
        end else begin
            gray_err <= gray_err;
        end
    end

    // Sticky level flag: a new violation beats a simultaneous clear.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            level_err <= 1'b0;
        end else if (over_s) begin
            level_err <= 1'b1;
        end else if (err_clr) begin
            level_err <= 1'b0;
        end else begin
            level_err <= level_err;
        end
    end

endmodule : r2w_ptr_sync

// File: tb/tb_r2w_ptr_sync.sv
// Directed bench for r2w_ptr_sync with hand-computed expectations
// (ADDRSIZE=7, SYNC_STAGES=2, AFULL_THRESH=120).
module tb_r2w_ptr_sync;

    logic       wclk;
    logic       wrst_n;
    logic [7:0] rptr_gray;
    logic [7:0] wptr_gray;
    logic       err_clr;
    logic [7:0] r2wptr;
    logic [7:0] wlevel;
    logic [7:0] wspace;
    logic       walmost_full;
    logic       gray_err;
    logic       level_err;

    int chk_cnt;
    int pass_cnt;

    r2w_ptr_sync #(
        .ADDRSIZE     (7),
        .SYNC_STAGES  (2),
        .AFULL_THRESH (120)
    ) dut (
        .wclk         (wclk),
        .wrst_n       (wrst_n),
        .rptr_gray    (rptr_gray),
        .wptr_gray    (wptr_gray),
        .err_clr      (err_clr),
        .r2wptr       (r2wptr),
        .wlevel       (wlevel),
        .wspace       (wspace),
        .walmost_full (walmost_full),
        .gray_err     (gray_err),
        .level_err    (level_err)
    );

    // Free-running write clock, 10 time units per period.
    initial begin
        wclk = 1'b0;
        forever #5 wclk = ~wclk;
    end

    // Compare one observed value against its expectation.
    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // Advance n falling edges; inputs change and outputs are sampled there.
    task automatic tick(input int n);
        repeat (n) @(negedge wclk);
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
    endtask

    // Directed stimulus sequence.
    initial begin
        chk_cnt   = 0;
        pass_cnt  = 0;
        wrst_n    = 1'b0;
        rptr_gray = 8'h5A;
        wptr_gray = 8'h33;
        err_clr   = 1'b0;

        // Reset state with arbitrary pointers present
        tick(3);
        check_val("rst_wlevel", 32'(wlevel), 32'd0);
        check_val("rst_wspace", 32'(wspace), 32'd128);
        check_val("rst_afull", 32'(walmost_full), 32'd0);
        check_val("rst_r2wptr", 32'(r2wptr), 32'd0);
        check_val("rst_gray_err", 32'(gray_err), 32'd0);
        check_val("rst_level_err", 32'(level_err), 32'd0);

        rptr_gray = 8'h00;
        wptr_gray = 8'h00;
        wrst_n    = 1'b1;
        tick(3);

        // Basic level: wptr bin 10, rptr 0, one cycle latency
        wptr_gray = 8'h0F;
        tick(1);
        check_val("lvl10_wlevel", 32'(wlevel), 32'd10);
        check_val("lvl10_wspace", 32'(wspace), 32'd118);
        check_val("lvl10_afull", 32'(walmost_full), 32'd0);

        // Read pointer step to bin 3: two edges to r2wptr, one more to level
        rptr_gray = 8'h02;
        tick(1);
        check_val("sync_lat_r2wptr_early", 32'(r2wptr), 32'h00);
        tick(1);
        check_val("sync_lat_r2wptr", 32'(r2wptr), 32'h02);
        check_val("sync_lat_wlevel_old", 32'(wlevel), 32'd10);
        tick(1);
        check_val("rstep_wlevel", 32'(wlevel), 32'd7);
        check_val("rstep_wspace", 32'(wspace), 32'd121);
        check_val("rstep_gray_err", 32'(gray_err), 32'd0);

        // Modular wrap: wptr bin 4, rptr bin 250 -> level 10
        wptr_gray = 8'h06;
        rptr_gray = 8'h87;
        tick(4);
        check_val("wrap_wlevel", 32'(wlevel), 32'd10);
        check_val("wrap_wspace", 32'(wspace), 32'd118);
        check_val("wrap_level_err", 32'(level_err), 32'd0);
        check_val("jump_gray_err", 32'(gray_err), 32'd1);
        pulse_clr();
        check_val("clr_gray_err", 32'(gray_err), 32'd0);

        // Move to rptr bin 255 (multi-bit jump, then cleared), wptr bin 1
        rptr_gray = 8'h80;
        wptr_gray = 8'h01;
        tick(4);
        check_val("r255_wlevel", 32'(wlevel), 32'd2);
        pulse_clr();
        // Pointer wrap 255 -> 0 is a single Gray bit: legal
        rptr_gray = 8'h00;
        tick(4);
        check_val("ptrwrap_wlevel", 32'(wlevel), 32'd1);
        check_val("ptrwrap_gray_err", 32'(gray_err), 32'd0);
        check_val("ptrwrap_level_err", 32'(level_err), 32'd0);

        // Almost-full threshold at 120
        wptr_gray = 8'h4C;
        tick(1);
        check_val("thr119_wlevel", 32'(wlevel), 32'd119);
        check_val("thr119_afull", 32'(walmost_full), 32'd0);
        wptr_gray = 8'h44;
        tick(1);
        check_val("thr120_afull", 32'(walmost_full), 32'd1);
        check_val("thr120_wspace", 32'(wspace), 32'd8);

        // Two-bit Gray jump 0x00 -> 0x03 on the read pointer
        rptr_gray = 8'h03;
        tick(2);
        check_val("gjump_r2wptr", 32'(r2wptr), 32'h03);
        check_val("gjump_gray_err_pre", 32'(gray_err), 32'd0);
        tick(1);
        check_val("gjump_gray_err", 32'(gray_err), 32'd1);
        tick(3);
        check_val("gjump_gray_err_held", 32'(gray_err), 32'd1);
        check_val("gjump_r2wptr_kept", 32'(r2wptr), 32'h03);
        pulse_clr();
        check_val("gjump_gray_err_clr", 32'(gray_err), 32'd0);

        // Walk rptr back to 0 with legal single-bit steps
        rptr_gray = 8'h01;
        tick(3);
        rptr_gray = 8'h00;
        tick(4);
        check_val("walk_gray_err", 32'(gray_err), 32'd0);
        check_val("walk_wlevel", 32'(wlevel), 32'd120);

        // Impossible level: wptr bin 200, rptr 0
        wptr_gray = 8'hAC;
        tick(1);
        check_val("over_wlevel", 32'(wlevel), 32'd128);
        check_val("over_wspace", 32'(wspace), 32'd0);
        check_val("over_afull", 32'(walmost_full), 32'd1);
        check_val("over_level_err", 32'(level_err), 32'd1);
        // Clear while the violation persists: set wins
        pulse_clr();
        check_val("over_clr_same_cycle", 32'(level_err), 32'd1);
        wptr_gray = 8'h00;
        tick(1);
        check_val("empty_wlevel", 32'(wlevel), 32'd0);
        check_val("empty_wspace", 32'(wspace), 32'd128);
        check_val("empty_level_err_sticky", 32'(level_err), 32'd1);
        pulse_clr();
        check_val("level_err_clr", 32'(level_err), 32'd0);

        // Gray violation coinciding with err_clr: set wins
        wptr_gray = 8'h03;
        rptr_gray = 8'h03;
        tick(2);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        check_val("gray_clr_same_cycle", 32'(gray_err), 32'd1);
        pulse_clr();
        check_val("gray_clr_after", 32'(gray_err), 32'd0);

        // Asynchronous reset mid-operation
        #1;
        wrst_n = 1'b0;
        #1;
        check_val("mid_rst_r2wptr", 32'(r2wptr), 32'd0);
        check_val("mid_rst_wspace", 32'(wspace), 32'd128);
        check_val("mid_rst_gray_err", 32'(gray_err), 32'd1 - 32'd1);
        tick(1);
        wptr_gray = 8'h0F;
        rptr_gray = 8'h01;
        wrst_n    = 1'b1;
        tick(1);
        check_val("post_rst_r2wptr", 32'(r2wptr), 32'h00);
        check_val("post_rst_wlevel", 32'(wlevel), 32'd10);
        tick(1);
        check_val("post_rst_r2wptr_sync", 32'(r2wptr), 32'h01);
        tick(1);
        check_val("post_rst_wlevel_sync", 32'(wlevel), 32'd9);
        check_val("post_rst_gray_err", 32'(gray_err), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule : tb_r2w_ptr_sync

// File: doc/r2w_ptr_sync.md
Name: r2w_ptr_sync

Overview:
Write-clock-domain receiver for the read pointer that the FIFO read side transmits as Gray code.
- Synchronizes the incoming Gray pointer into wclk and hands the synchronized Gray value to the write-side full logic.
- Decodes both pointers to binary and produces a registered fill level, free-space count and almost-full flag.
- Flags protocol violations: a multi-bit Gray step, or an impossible level.
- Sits between the read pointer CDC path and the write module / producer flow control.

Parameters:
ADDRSIZE, 7, address width; FIFO depth DEPTH = 2**ADDRSIZE; pointers are ADDRSIZE+1 bits.
SYNC_STAGES, 2, number of synchronizer flops (legal range 2..4).
AFULL_THRESH, 120, level at or above which walmost_full asserts (legal range 1..DEPTH).

Ports:
wclk  input  1  write clock
wrst_n  input  1  asynchronous active-low reset, write domain
rptr_gray  input  ADDRSIZE+1  read pointer Gray code, launched from the rclk domain (asynchronous to wclk)
wptr_gray  input  ADDRSIZE+1  write pointer Gray code, wclk domain, no synchronization needed
err_clr  input  1  synchronous clear for the sticky error flags
r2wptr  output  ADDRSIZE+1  synchronized read pointer Gray code, feeds the write-side full compare
wlevel  output  ADDRSIZE+1  registered FIFO occupancy, 0..DEPTH
wspace  output  ADDRSIZE+1  registered free entries, DEPTH - wlevel
walmost_full  output  1  registered, wlevel >= AFULL_THRESH
gray_err  output  1  sticky; synchronized pointer changed by more than one bit in a single wclk cycle
level_err  output  1  sticky; computed level exceeded DEPTH

Behaviour:
- Reset (wrst_n low, asynchronous): all sync flops, r2wptr and the previous-value register go to 0. wlevel=0, wspace=DEPTH, walmost_full=0, gray_err=0, level_err=0.
- Synchronizer:
  - SYNC_STAGES-flop chain on rptr_gray.
  - r2wptr is the last stage; no combinational path from rptr_gray.
  - A change on rptr_gray sampled at edge t appears on r2wptr at edge t+SYNC_STAGES-1. Counted from the first edge after the change, that is SYNC_STAGES edges.
- Decode:
  - rbin = gray2bin(r2wptr) and wbin = gray2bin(wptr_gray), both combinational.
  - diff = (wbin - rbin) modulo 2**(ADDRSIZE+1). No sign extension, so wrap-around is handled naturally.
- Level stage, registered every wclk:
  - wlevel <= diff.
  - wspace <= DEPTH - diff.
  - walmost_full <= (diff >= AFULL_THRESH).
  - If diff > DEPTH: wlevel saturates to DEPTH, wspace <= 0, walmost_full <= 1, level_err set.
- Latency:
  - wptr_gray change -> level outputs after 1 wclk.
  - rptr_gray change -> level outputs after SYNC_STAGES+1 wclk.
- Gray check:
  - r2wptr_d holds r2wptr delayed one cycle, reset 0.
  - If popcount(r2wptr ^ r2wptr_d) > 1, gray_err is set at the next edge.
  - A zero-bit or one-bit change is legal.
- Sticky flags:
  - Cleared by err_clr=1 at a clock edge.
  - If a set condition and err_clr occur in the same cycle, set wins.
  - Error flags do not alter r2wptr.
- Reset mid-operation: everything returns to reset values immediately. After release, the first level value is computed from the then-current pointers, with SYNC_STAGES cycles of sync refill.
- Boundaries:
  - Empty (diff=0): wlevel=0, wspace=DEPTH.
  - Full (diff=DEPTH): wlevel=DEPTH, wspace=0.
  - Pointer wrap (binary 2**(ADDRSIZE+1)-1 -> 0) is a single Gray bit change and is not an error.
- Level is conservative: the read pointer lags, so wlevel may overstate occupancy but never understates it.

Decomposition:
- Shared package fifo_pkg holds:
  - ADDRSIZE default.
  - DEPTH derived constant.
  - Pointer typedef ptr_t (logic [ADDRSIZE:0]).
  - Functions bin2gray and gray2bin.
- One sub-module, sync_ff_chain (parameters WIDTH, STAGES), is reused for the write-to-read direction too.

Test Plan:
1. Assert wrst_n=0 with random pointers -> wlevel=0, wspace=128, walmost_full=0, r2wptr=0, errors=0.
2. rptr_gray=0x00, wptr_gray=0x0F (bin 10) -> after 1 wclk: wlevel=10, wspace=118, walmost_full=0.
3. rptr_gray steps 0x00->0x02 (bin 3) just before edge t, wptr bin 10 -> r2wptr=0x02 at edge t+1; wlevel=7 at edge t+2; no gray_err.
4. Wrap: wptr_gray=0x06 (bin 4), rptr_gray=0x87 (bin 250), settled -> wlevel=10, wspace=118, level_err=0.
5. Threshold: rptr 0; wptr_gray=0x4C (bin 119) -> walmost_full=0; then 0x44 (bin 120) -> walmost_full=1, wspace=8 after 1 cycle.
6. Errors:
   - rptr_gray jumps 0x00->0x03 -> gray_err=1 one cycle after r2wptr updates, held until err_clr pulse.
   - wptr_gray=0xAC (bin 200), rptr 0 -> level_err=1, wlevel=128, wspace=0.
   - err_clr asserted in the same cycle as a new violation -> flag stays 1.
